// File: rtl/axi4_field_pkg.sv
// Shared definitions for the AXI4 field reader: response codes and width helpers.
package axi4_field_pkg;

    // AXI read response codes used by this block.
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    // Width of the field index; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned data_w,
                                              input int unsigned field_w);
        int unsigned n;
        n = data_w / field_w;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Packed width of one buffered result {field, id, resp}.
    function automatic int unsigned entry_width(input int unsigned field_w,
                                                input int unsigned id_w);
        return field_w + id_w + 2;
    endfunction

endpackage

// File: rtl/axi4_resp_fifo.sv
// Synchronous result FIFO with asynchronous active-low reset; head is zero when empty.
module axi4_resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/axi4_field_reader.sv
// Selects a FIELD_W-bit field from src_word on each AR handshake and returns it
// in order on an R-style channel, flagging bad or unprivileged selects as SLVERR.
module axi4_field_reader
    import axi4_field_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIELD_W    = 1,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ID_W       = 4,
    parameter bit          PROT_CHECK = 1'b0,
    parameter logic [DATA_W/FIELD_W-1:0] PRIV_MASK = '0,
    parameter bit          VERBOSE    = 1'b0,
    localparam int unsigned NFIELD  = DATA_W / FIELD_W,
    localparam int unsigned SEL_W   = sel_width(DATA_W, FIELD_W),
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1,
    localparam int unsigned ENTRY_W = entry_width(FIELD_W, ID_W)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               arvalid,
    output logic               arready,
    input  logic [SEL_W-1:0]   arsel,
    input  logic [ID_W-1:0]    arid,
    input  logic [2:0]         arprot,
    input  logic [DATA_W-1:0]  src_word,
    output logic               rvalid,
    input  logic               rready,
    output logic [FIELD_W-1:0] rdata,
    output logic [ID_W-1:0]    rid,
    output logic [1:0]         rresp,
    output logic [CNT_W-1:0]   count
);

    typedef struct packed {
        logic [FIELD_W-1:0] field;
        logic [ID_W-1:0]    id;
        resp_e              resp;
    } entry_t;

    logic               arready_q;
    logic               ar_hs;
    logic               r_hs;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   cnt_next;
    logic               sel_hit;
    logic               sel_priv;
    logic [FIELD_W-1:0] sel_field;
    entry_t             push_entry;
    entry_t             head_entry;
    logic [ENTRY_W-1:0] head_word;
    logic               unused_prot;

    assign unused_prot = &{1'b0, arprot[2:1]};

    assign arready    = arready_q;
    assign ar_hs      = arvalid && arready_q && !fifo_full;
    assign r_hs       = !fifo_empty && rready;
    assign cnt_next   = fifo_count + CNT_W'(ar_hs) - CNT_W'(r_hs);
    assign head_entry = entry_t'(head_word);

    assign rvalid = !fifo_empty;
    assign rdata  = head_entry.field;
    assign rid    = head_entry.id;
    assign rresp  = head_entry.resp;
    assign count  = fifo_count;

    // Field mux: a loop over valid indices avoids slicing past DATA_W on out-of-range selects.
    always_comb begin
        sel_hit   = 1'b0;
        sel_priv  = 1'b0;
        sel_field = '0;
        for (int unsigned i = 0; i < NFIELD; i++) begin
            if (32'(arsel) == i) begin
                sel_hit   = 1'b1;
                sel_priv  = PRIV_MASK[i];
                sel_field = src_word[i*FIELD_W +: FIELD_W];
            end
        end
    end

    // Build the result entry: range check first, then privilege check.
    always_comb begin
        push_entry.field = '0;
        push_entry.id    = arid;
        push_entry.resp  = RESP_OKAY;
        if (!sel_hit) begin
            push_entry.resp = RESP_SLVERR;
        end else if (PROT_CHECK && sel_priv && !arprot[0]) begin
            push_entry.resp = RESP_SLVERR;
        end else begin
            push_entry.field = sel_field;
        end
    end

    // arready tracks the post-edge occupancy so a freed slot shows up one cycle after the pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) arready_q <= 1'b0;
        else         arready_q <= (cnt_next != CNT_W'(DEPTH));
    end

    axi4_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (ar_hs),
        .wdata  (push_entry),
        .pop    (r_hs),
        .rdata  (head_word),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    generate
        if (VERBOSE) begin : g_verbose
`ifndef SYNTHESIS
            // Simulation trace of every AR and R handshake.
            always_ff @(posedge clk) begin
                if (resetn && ar_hs)
                    $display("%m AR id=%0h sel=%0d resp=%0h", arid, arsel, push_entry.resp);
                if (resetn && r_hs)
                    $display("%m R  id=%0h data=%0h resp=%0h", rid, rdata, rresp);
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_axi4_field_reader.sv
// Directed self-checking bench for axi4_field_reader across four parameter sets.
module tb_axi4_field_reader;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // d_: default parameters
    logic       d_arvalid, d_arready, d_rvalid, d_rready;
    logic [2:0] d_arsel, d_arprot, d_count;
    logic [3:0] d_arid, d_rid;
    logic [7:0] d_src;
    logic [0:0] d_rdata;
    logic [1:0] d_rresp;
    // a_: privilege checking on field 7
    logic       a_arvalid, a_arready, a_rvalid, a_rready;
    logic [2:0] a_arsel, a_arprot, a_count;
    logic [3:0] a_arid, a_rid;
    logic [7:0] a_src;
    logic [0:0] a_rdata;
    logic [1:0] a_rresp;
    // b_: 32-bit word, byte fields
    logic        b_arvalid, b_arready, b_rvalid, b_rready;
    logic [1:0]  b_arsel;
    logic [2:0]  b_arprot, b_count;
    logic [3:0]  b_arid, b_rid;
    logic [31:0] b_src;
    logic [7:0]  b_rdata;
    logic [1:0]  b_rresp;
    // c_: 24-bit word, byte fields (index 3 out of range)
    logic        c_arvalid, c_arready, c_rvalid, c_rready;
    logic [1:0]  c_arsel;
    logic [2:0]  c_arprot, c_count;
    logic [3:0]  c_arid, c_rid;
    logic [23:0] c_src;
    logic [7:0]  c_rdata;
    logic [1:0]  c_rresp;

    axi4_field_reader u_d (
        .clk(clk), .resetn(resetn), .arvalid(d_arvalid), .arready(d_arready),
        .arsel(d_arsel), .arid(d_arid), .arprot(d_arprot), .src_word(d_src),
        .rvalid(d_rvalid), .rready(d_rready), .rdata(d_rdata), .rid(d_rid),
        .rresp(d_rresp), .count(d_count)
    );

    axi4_field_reader #(.PROT_CHECK(1'b1), .PRIV_MASK(8'h80)) u_a (
        .clk(clk), .resetn(resetn), .arvalid(a_arvalid), .arready(a_arready),
        .arsel(a_arsel), .arid(a_arid), .arprot(a_arprot), .src_word(a_src),
        .rvalid(a_rvalid), .rready(a_rready), .rdata(a_rdata), .rid(a_rid),
        .rresp(a_rresp), .count(a_count)
    );

    axi4_field_reader #(.DATA_W(32), .FIELD_W(8)) u_b (
        .clk(clk), .resetn(resetn), .arvalid(b_arvalid), .arready(b_arready),
        .arsel(b_arsel), .arid(b_arid), .arprot(b_arprot), .src_word(b_src),
        .rvalid(b_rvalid), .rready(b_rready), .rdata(b_rdata), .rid(b_rid),
        .rresp(b_rresp), .count(b_count)
    );

    axi4_field_reader #(.DATA_W(24), .FIELD_W(8)) u_c (
        .clk(clk), .resetn(resetn), .arvalid(c_arvalid), .arready(c_arready),
        .arsel(c_arsel), .arid(c_arid), .arprot(c_arprot), .src_word(c_src),
        .rvalid(c_rvalid), .rready(c_rready), .rdata(c_rdata), .rid(c_rid),
        .rresp(c_rresp), .count(c_count)
    );

    typedef struct {
        int         dut;
        logic [31:0] src;
        logic [4:0]  sel;
        logic [3:0]  id;
        logic [2:0]  prot;
        logic [7:0]  exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vt [13];
    int   bb_exp [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [4:0] sel, input logic [3:0] id,
                         input logic [2:0] prot, input logic [31:0] src);
        case (d)
            1: begin a_arvalid = v; a_arsel = sel[2:0]; a_arid = id; a_arprot = prot; a_src = src[7:0];  end
            2: begin b_arvalid = v; b_arsel = sel[1:0]; b_arid = id; b_arprot = prot; b_src = src;       end
            3: begin c_arvalid = v; c_arsel = sel[1:0]; c_arid = id; c_arprot = prot; c_src = src[23:0]; end
            default: begin d_arvalid = v; d_arsel = sel[2:0]; d_arid = id; d_arprot = prot; d_src = src[7:0]; end
        endcase
    endtask

    task automatic set_rready(input int d, input logic v);
        case (d)
            1: a_rready = v;
            2: b_rready = v;
            3: c_rready = v;
            default: d_rready = v;
        endcase
    endtask

    task automatic sample(input int d, output logic ar, output logic rv, output logic [7:0] data,
                          output logic [3:0] id, output logic [1:0] resp);
        case (d)
            1: begin ar = a_arready; rv = a_rvalid; data = {7'b0, a_rdata}; id = a_rid; resp = a_rresp; end
            2: begin ar = b_arready; rv = b_rvalid; data = b_rdata;         id = b_rid; resp = b_rresp; end
            3: begin ar = c_arready; rv = c_rvalid; data = c_rdata;         id = c_rid; resp = c_rresp; end
            default: begin ar = d_arready; rv = d_rvalid; data = {7'b0, d_rdata}; id = d_rid; resp = d_rresp; end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       s_ar, s_rv;
        logic [7:0] s_data;
        logic [3:0] s_id;
        logic [1:0] s_resp;

        vt[0]  = '{1, 32'h80,       5'd7, 4'd1,  3'b000, 8'h00, 2'b10};
        vt[1]  = '{1, 32'h80,       5'd7, 4'd2,  3'b001, 8'h01, 2'b00};
        vt[2]  = '{1, 32'h7F,       5'd7, 4'd3,  3'b001, 8'h00, 2'b00};
        vt[3]  = '{1, 32'h40,       5'd6, 4'd4,  3'b000, 8'h01, 2'b00};
        vt[4]  = '{1, 32'hFF,       5'd7, 4'd5,  3'b110, 8'h00, 2'b10};
        vt[5]  = '{2, 32'hDEADBEEF, 5'd0, 4'd5,  3'b000, 8'hEF, 2'b00};
        vt[6]  = '{2, 32'hDEADBEEF, 5'd1, 4'd6,  3'b000, 8'hBE, 2'b00};
        vt[7]  = '{2, 32'hDEADBEEF, 5'd2, 4'd7,  3'b000, 8'hAD, 2'b00};
        vt[8]  = '{2, 32'hDEADBEEF, 5'd3, 4'd8,  3'b000, 8'hDE, 2'b00};
        vt[9]  = '{3, 32'h123456,   5'd3, 4'd9,  3'b000, 8'h00, 2'b10};
        vt[10] = '{3, 32'h123456,   5'd2, 4'd10, 3'b000, 8'h12, 2'b00};
        vt[11] = '{3, 32'h123456,   5'd0, 4'd11, 3'b000, 8'h56, 2'b00};
        vt[12] = '{3, 32'h123456,   5'd1, 4'd12, 3'b000, 8'h34, 2'b00};

        for (int d = 0; d < 4; d++) begin
            drive(d, 1'b0, 5'd0, 4'd0, 3'b000, 32'h0);
            set_rready(d, 1'b0);
        end

        // Reset state
        #3;
        check("rst arready", d_arready, 0);
        check("rst rvalid", d_rvalid, 0);
        check("rst rdata", d_rdata, 0);
        check("rst rid", d_rid, 0);
        check("rst rresp", d_rresp, 0);
        check("rst count", d_count, 0);
        check("rst b arready", b_arready, 0);
        tick;
        tick;
        resetn = 1'b1;
        check("release arready before edge", d_arready, 0);
        tick;
        check("release arready after edge", d_arready, 1);
        check("release rvalid", d_rvalid, 0);

        // Back-to-back selects of 8'hA5 with rready held high
        d_rready = 1'b1;
        check("b2b rvalid before first", d_rvalid, 0);
        for (int k = 0; k < 8; k++) begin
            drive(0, 1'b1, 5'(k), 4'(k), 3'b000, 32'hA5);
            tick;
            check($sformatf("b2b%0d rvalid", k), d_rvalid, 1);
            check($sformatf("b2b%0d rdata", k), d_rdata, bb_exp[k]);
            check($sformatf("b2b%0d rid", k), d_rid, k);
            check($sformatf("b2b%0d rresp", k), d_rresp, 0);
            check($sformatf("b2b%0d arready", k), d_arready, 1);
        end
        d_arvalid = 1'b0;
        tick;
        check("b2b drained rvalid", d_rvalid, 0);
        check("b2b drained count", d_count, 0);
        d_rready = 1'b0;

        // Fill to DEPTH with rready low, then free a single slot
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 5'd0, 4'(k), 3'b000, 32'hA5);
            check($sformatf("fill%0d arready", k), d_arready, 1);
            tick;
        end
        drive(0, 1'b1, 5'd0, 4'd4, 3'b000, 32'hA5);
        check("full count", d_count, 4);
        check("full arready", d_arready, 0);
        tick;
        check("full hold count", d_count, 4);
        check("full hold arready", d_arready, 0);
        check("full head rid", d_rid, 0);
        d_rready = 1'b1;
        tick;
        d_rready = 1'b0;
        check("after pop count", d_count, 3);
        check("after pop arready", d_arready, 1);
        check("after pop head rid", d_rid, 1);
        tick;
        d_arvalid = 1'b0;
        check("refill count", d_count, 4);
        check("refill arready", d_arready, 0);
        d_rready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain%0d rvalid", k), d_rvalid, 1);
            check($sformatf("drain%0d rid", k), d_rid, k);
            check($sformatf("drain%0d rdata", k), d_rdata, 1);
            tick;
        end
        check("drain empty rvalid", d_rvalid, 0);
        check("drain empty count", d_count, 0);
        d_rready = 1'b0;

        // Table of single transactions across the parameterised instances
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].dut, 1'b1, vt[i].sel, vt[i].id, vt[i].prot, vt[i].src);
            sample(vt[i].dut, s_ar, s_rv, s_data, s_id, s_resp);
            check($sformatf("vec%0d arready", i), s_ar, 1);
            tick;
            drive(vt[i].dut, 1'b0, vt[i].sel, vt[i].id, vt[i].prot, vt[i].src);
            sample(vt[i].dut, s_ar, s_rv, s_data, s_id, s_resp);
            check($sformatf("vec%0d rvalid", i), s_rv, 1);
            check($sformatf("vec%0d rdata", i), s_data, vt[i].exp_data);
            check($sformatf("vec%0d rid", i), s_id, vt[i].id);
            check($sformatf("vec%0d rresp", i), s_resp, vt[i].exp_resp);
            set_rready(vt[i].dut, 1'b1);
            tick;
            set_rready(vt[i].dut, 1'b0);
            sample(vt[i].dut, s_ar, s_rv, s_data, s_id, s_resp);
            check($sformatf("vec%0d popped rvalid", i), s_rv, 0);
        end

        // Reset with three responses pending
        d_rready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 5'(k), 4'(9 + k), 3'b000, 32'hA5);
            tick;
        end
        d_arvalid = 1'b0;
        check("pend count", d_count, 3);
        check("pend rvalid", d_rvalid, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst rvalid", d_rvalid, 0);
        check("midrst arready", d_arready, 0);
        check("midrst count", d_count, 0);
        check("midrst rdata", d_rdata, 0);
        check("midrst rid", d_rid, 0);
        tick;
        tick;
        resetn = 1'b1;
        check("rerelease arready before edge", d_arready, 0);
        tick;
        check("rerelease arready", d_arready, 1);
        check("rerelease rvalid", d_rvalid, 0);
        tick;
        check("no stale rvalid", d_rvalid, 0);
        drive(0, 1'b1, 5'd5, 4'd6, 3'b000, 32'hA5);
        tick;
        d_arvalid = 1'b0;
        check("post rst rvalid", d_rvalid, 1);
        check("post rst rdata", d_rdata, 1);
        check("post rst rid", d_rid, 6);
        check("post rst rresp", d_rresp, 0);
        check("post rst count", d_count, 1);
        d_rready = 1'b1;
        tick;
        d_rready = 1'b0;
        check("post rst drained", d_rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
